// File: rtl/jtag_snoop_engine.sv
// Passive JTAG snooper: synchronises the TAP pins, tracks the 1149.1 state,
// captures IR scans and packs armed DR scans (TDI or TDO) into RAM words.
module jtag_snoop_engine #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned IR_W        = 8,
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                       sclk,
  input  logic                       reset,
  input  logic                       TCK,
  input  logic                       TMS,
  input  logic                       TDI,
  input  logic                       TDO,
  input  logic                       enable_i,
  input  logic                       src_sel_i,
  input  logic                       wrap_mode_i,
  input  logic                       clear_int_i,
  output logic                       int_o,
  output logic                       overflow_o,
  output logic [IR_W-1:0]            ir_value_o,
  output logic [$clog2(IR_W+1)-1:0]  ir_len_o,
  output logic [LEN_W-1:0]           dr_len_o,
  output logic [3:0]                 tap_state_o,
  output logic                       ram_we_o,
  output logic [ADDR_W-1:0]          ram_waddr_o,
  output logic [DATA_W-1:0]          ram_wdata_o
);

  localparam int unsigned IRC_W = $clog2(IR_W+1);
  localparam int unsigned POS_W = $clog2(DATA_W);

  localparam logic [3:0] ST_TLR   = 4'hF;
  localparam logic [3:0] ST_RTI   = 4'hC;
  localparam logic [3:0] ST_SELDR = 4'h7;
  localparam logic [3:0] ST_CAPDR = 4'h6;
  localparam logic [3:0] ST_SHDR  = 4'h2;
  localparam logic [3:0] ST_EX1DR = 4'h1;
  localparam logic [3:0] ST_PAUDR = 4'h3;
  localparam logic [3:0] ST_EX2DR = 4'h0;
  localparam logic [3:0] ST_UPDDR = 4'h5;
  localparam logic [3:0] ST_SELIR = 4'h4;
  localparam logic [3:0] ST_CAPIR = 4'hE;
  localparam logic [3:0] ST_SHIR  = 4'hA;
  localparam logic [3:0] ST_EX1IR = 4'h9;
  localparam logic [3:0] ST_PAUIR = 4'hB;
  localparam logic [3:0] ST_EX2IR = 4'h8;
  localparam logic [3:0] ST_UPDIR = 4'hD;

  // Pin synchronisers
  logic [SYNC_STAGES-1:0] tck_sync_q, tck_sync_d;
  logic [SYNC_STAGES-1:0] tms_sync_q, tms_sync_d;
  logic [SYNC_STAGES-1:0] tdi_sync_q, tdi_sync_d;
  logic [SYNC_STAGES-1:0] tdo_sync_q, tdo_sync_d;
  logic                   tck_prev_q, tck_prev_d;

  logic [3:0]          state_q, state_d;
  logic [IR_W-1:0]     ir_shift_q, ir_shift_d;
  logic [IRC_W-1:0]    ir_cnt_q, ir_cnt_d;
  logic [IR_W-1:0]     ir_value_q, ir_value_d;
  logic [IRC_W-1:0]    ir_len_q, ir_len_d;
  logic                armed_q, armed_d;
  logic                src_q, src_d;
  logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic                wrapped_q, wrapped_d;
  logic [LEN_W-1:0]    dr_len_q, dr_len_d;
  logic                int_q, int_d;
  logic                overflow_q, overflow_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_waddr_q, ram_waddr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;

  logic tck_s, tms_s, tdi_s, tdo_s, tck_rise;
  logic cap_bit;
  logic [DATA_W-1:0] word_v;

  assign tck_s    = tck_sync_q[SYNC_STAGES-1];
  assign tms_s    = tms_sync_q[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync_q[SYNC_STAGES-1];
  assign tdo_s    = tdo_sync_q[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_prev_q;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
    logic [3:0] n;
    case (s)
      ST_TLR:   n = m ? ST_TLR   : ST_RTI;
      ST_RTI:   n = m ? ST_SELDR : ST_RTI;
      ST_SELDR: n = m ? ST_SELIR : ST_CAPDR;
      ST_CAPDR: n = m ? ST_EX1DR : ST_SHDR;
      ST_SHDR:  n = m ? ST_EX1DR : ST_SHDR;
      ST_EX1DR: n = m ? ST_UPDDR : ST_PAUDR;
      ST_PAUDR: n = m ? ST_EX2DR : ST_PAUDR;
      ST_EX2DR: n = m ? ST_UPDDR : ST_SHDR;
      ST_UPDDR: n = m ? ST_SELDR : ST_RTI;
      ST_SELIR: n = m ? ST_TLR   : ST_CAPIR;
      ST_CAPIR: n = m ? ST_EX1IR : ST_SHIR;
      ST_SHIR:  n = m ? ST_EX1IR : ST_SHIR;
      ST_EX1IR: n = m ? ST_UPDIR : ST_PAUIR;
      ST_PAUIR: n = m ? ST_EX2IR : ST_PAUIR;
      ST_EX2IR: n = m ? ST_UPDIR : ST_SHIR;
      ST_UPDIR: n = m ? ST_SELDR : ST_RTI;
      default:  n = ST_TLR;
    endcase
    return n;
  endfunction

  always_comb begin
    tck_sync_d = {tck_sync_q[SYNC_STAGES-2:0], TCK};
    tms_sync_d = {tms_sync_q[SYNC_STAGES-2:0], TMS};
    tdi_sync_d = {tdi_sync_q[SYNC_STAGES-2:0], TDI};
    tdo_sync_d = {tdo_sync_q[SYNC_STAGES-2:0], TDO};
    tck_prev_d = tck_s;

    state_d     = state_q;
    ir_shift_d  = ir_shift_q;
    ir_cnt_d    = ir_cnt_q;
    ir_value_d  = ir_value_q;
    ir_len_d    = ir_len_q;
    armed_d     = armed_q;
    src_d       = src_q;
    bit_cnt_d   = bit_cnt_q;
    pos_d       = pos_q;
    word_d      = word_q;
    wr_ptr_d    = wr_ptr_q;
    wrapped_d   = wrapped_q;
    dr_len_d    = dr_len_q;
    int_d       = int_q;
    overflow_d  = overflow_q;
    ram_we_d    = 1'b0;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;
    cap_bit     = 1'b0;
    word_v      = word_q;

    // Clear is applied first so any set on the same cycle overrides it
    if (clear_int_i) begin
      int_d      = 1'b0;
      overflow_d = 1'b0;
    end

    if (tck_rise) begin
      state_d = tap_next(state_q, tms_s);

      if (state_q == ST_SHIR) begin
        ir_shift_d = {tdi_s, ir_shift_q[IR_W-1:1]};
        if (ir_cnt_q != IRC_W'(IR_W)) ir_cnt_d = ir_cnt_q + 1'b1;
      end
      if (state_d == ST_CAPIR) ir_cnt_d = '0;
      if (state_d == ST_UPDIR) begin
        ir_value_d = ir_shift_q >> (IR_W - ir_cnt_q);
        ir_len_d   = ir_cnt_q;
      end

      if (state_d == ST_CAPDR) begin
        armed_d = enable_i & ~int_q;
        src_d   = src_sel_i;
        if (enable_i & ~int_q) begin
          wr_ptr_d   = '0;
          bit_cnt_d  = '0;
          pos_d      = '0;
          word_d     = '0;
          wrapped_d  = 1'b0;
          overflow_d = 1'b0;
        end
      end

      if (state_q == ST_SHDR && armed_q) begin
        cap_bit        = src_q ? tdo_s : tdi_s;
        word_v[pos_q]  = cap_bit;
        if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + 1'b1;
        // Full word or scan exit flushes; past the last address the write
        // either wraps or is dropped, flagging overflow in both cases
        if (pos_q == POS_W'(DATA_W-1) || tms_s) begin
          if (wrapped_q) overflow_d = 1'b1;
          if (!wrapped_q || wrap_mode_i) begin
            ram_we_d    = 1'b1;
            ram_waddr_d = wr_ptr_q;
            ram_wdata_d = word_v;
          end
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == '1) wrapped_d = 1'b1;
          word_d = '0;
          pos_d  = '0;
        end else begin
          word_d = word_v;
          pos_d  = pos_q + 1'b1;
        end
      end

      if (state_d == ST_UPDDR && armed_q) begin
        dr_len_d = bit_cnt_q;
        int_d    = 1'b1;
        armed_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (reset) begin
      tck_sync_q  <= '0;
      tms_sync_q  <= '0;
      tdi_sync_q  <= '0;
      tdo_sync_q  <= '0;
      tck_prev_q  <= 1'b0;
      state_q     <= ST_TLR;
      ir_shift_q  <= '0;
      ir_cnt_q    <= '0;
      ir_value_q  <= '0;
      ir_len_q    <= '0;
      armed_q     <= 1'b0;
      src_q       <= 1'b0;
      bit_cnt_q   <= '0;
      pos_q       <= '0;
      word_q      <= '0;
      wr_ptr_q    <= '0;
      wrapped_q   <= 1'b0;
      dr_len_q    <= '0;
      int_q       <= 1'b0;
      overflow_q  <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
    end else begin
      tck_sync_q  <= tck_sync_d;
      tms_sync_q  <= tms_sync_d;
      tdi_sync_q  <= tdi_sync_d;
      tdo_sync_q  <= tdo_sync_d;
      tck_prev_q  <= tck_prev_d;
      state_q     <= state_d;
      ir_shift_q  <= ir_shift_d;
      ir_cnt_q    <= ir_cnt_d;
      ir_value_q  <= ir_value_d;
      ir_len_q    <= ir_len_d;
      armed_q     <= armed_d;
      src_q       <= src_d;
      bit_cnt_q   <= bit_cnt_d;
      pos_q       <= pos_d;
      word_q      <= word_d;
      wr_ptr_q    <= wr_ptr_d;
      wrapped_q   <= wrapped_d;
      dr_len_q    <= dr_len_d;
      int_q       <= int_d;
      overflow_q  <= overflow_d;
      ram_we_q    <= ram_we_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign int_o       = int_q;
  assign overflow_o  = overflow_q;
  assign ir_value_o  = ir_value_q;
  assign ir_len_o    = ir_len_q;
  assign dr_len_o    = dr_len_q;
  assign tap_state_o = state_q;
  assign ram_we_o    = ram_we_q;
  assign ram_waddr_o = ram_waddr_q;
  assign ram_wdata_o = ram_wdata_q;

endmodule

// File: tb/tb_jtag_snoop_engine.sv
// Directed bench for jtag_snoop_engine: bit-banged TAP sequences with
// hand-computed IR/DR results and a log of RAM write strobes.
module tb_jtag_snoop_engine;

  logic        sclk = 1'b0;
  logic        reset, TCK, TMS, TDI, TDO;
  logic        enable_i, src_sel_i, wrap_mode_i, clear_int_i;
  logic        int_o, overflow_o;
  logic [7:0]  ir_value_o;
  logic [3:0]  ir_len_o;
  logic [15:0] dr_len_o;
  logic [3:0]  tap_state_o;
  logic        ram_we_o;
  logic [1:0]  ram_waddr_o;
  logic [31:0] ram_wdata_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [1:0]  wr_addrs[$];
  logic [31:0] wr_datas[$];

  jtag_snoop_engine #(
    .DATA_W(32), .ADDR_W(2), .IR_W(8), .LEN_W(16), .SYNC_STAGES(2)
  ) dut (
    .sclk(sclk), .reset(reset), .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO),
    .enable_i(enable_i), .src_sel_i(src_sel_i), .wrap_mode_i(wrap_mode_i),
    .clear_int_i(clear_int_i), .int_o(int_o), .overflow_o(overflow_o),
    .ir_value_o(ir_value_o), .ir_len_o(ir_len_o), .dr_len_o(dr_len_o),
    .tap_state_o(tap_state_o), .ram_we_o(ram_we_o), .ram_waddr_o(ram_waddr_o),
    .ram_wdata_o(ram_wdata_o)
  );

  always #5 sclk = ~sclk;

  always @(negedge sclk) begin
    if (ram_we_o) begin
      wr_addrs.push_back(ram_waddr_o);
      wr_datas.push_back(ram_wdata_o);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic tck_cycle(input logic tms, input logic tdi, input logic tdo);
    TMS = tms; TDI = tdi; TDO = tdo; TCK = 1'b0;
    wait_clk(4);
    TCK = 1'b1;
    wait_clk(4);
  endtask

  task automatic clear_log();
    wr_addrs.delete();
    wr_datas.delete();
  endtask

  task automatic pulse_clear();
    clear_int_i = 1'b1;
    wait_clk(1);
    clear_int_i = 1'b0;
    wait_clk(1);
  endtask

  // RTI -> SelDR -> CapDR -> ShDR
  task automatic dr_enter();
    tck_cycle(1'b1, 1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0, 1'b0);
  endtask

  // The unselected pin carries the inverted bit so a wrong source is visible
  task automatic dr_bits(input logic [191:0] data, input int unsigned n,
                         input logic src, input logic last_tms);
    for (int unsigned i = 0; i < n; i++) begin
      logic b, m;
      b = data[i];
      m = (i == n - 1) && last_tms;
      if (src) tck_cycle(m, ~b, b);
      else     tck_cycle(m, b, ~b);
    end
  endtask

  // Ex1DR -> UpdDR -> RTI
  task automatic dr_scan(input logic [191:0] data, input int unsigned n, input logic src);
    dr_enter();
    dr_bits(data, n, src, 1'b1);
    tck_cycle(1'b1, 1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0, 1'b0);
    wait_clk(4);
  endtask

  initial begin
    logic [191:0] ov_data;
    logic [7:0]   ir_pat;

    reset = 1'b1; TCK = 1'b0; TMS = 1'b0; TDI = 1'b0; TDO = 1'b0;
    enable_i = 1'b0; src_sel_i = 1'b0; wrap_mode_i = 1'b0; clear_int_i = 1'b0;
    wait_clk(3);
    check("rst_tap",      tap_state_o, 4'hF);
    check("rst_int",      int_o, 1'b0);
    check("rst_ovf",      overflow_o, 1'b0);
    check("rst_irval",    ir_value_o, 8'h00);
    check("rst_dr_len",   dr_len_o, 16'd0);
    check("rst_we",       ram_we_o, 1'b0);
    reset = 1'b0;
    wait_clk(2);

    // IR scan of 0x5A
    ir_pat = 8'h5A;
    tck_cycle(1'b0, 1'b0, 1'b0);
    tck_cycle(1'b1, 1'b0, 1'b0);
    tck_cycle(1'b1, 1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 8; i++) tck_cycle(i == 7, ir_pat[i], 1'b0);
    tck_cycle(1'b1, 1'b0, 1'b0);
    wait_clk(4);
    check("ir_value", ir_value_o, 8'h5A);
    check("ir_len",   ir_len_o, 4'd8);
    check("ir_tap",   tap_state_o, 4'hD);
    tck_cycle(1'b0, 1'b0, 1'b0);

    // 40-bit TDI scan: one full word plus a flushed partial word
    enable_i = 1'b1; src_sel_i = 1'b0;
    clear_log();
    dr_scan(192'h12_3456789A, 40, 1'b0);
    check("dr40_nwr",   wr_datas.size(), 2);
    check("dr40_a0",    wr_addrs[0], 2'd0);
    check("dr40_d0",    wr_datas[0], 32'h3456789A);
    check("dr40_a1",    wr_addrs[1], 2'd1);
    check("dr40_d1",    wr_datas[1], 32'h00000012);
    check("dr40_len",   dr_len_o, 16'd40);
    check("dr40_int",   int_o, 1'b1);
    check("dr40_tap",   tap_state_o, 4'hC);

    // TDO source after clearing the interrupt
    pulse_clear();
    check("clr_int", int_o, 1'b0);
    src_sel_i = 1'b1;
    clear_log();
    dr_scan(192'hDEADBEEF, 32, 1'b1);
    check("tdo_nwr",  wr_datas.size(), 1);
    check("tdo_d0",   wr_datas[0], 32'hDEADBEEF);
    check("tdo_len",  dr_len_o, 16'd32);
    check("tdo_int",  int_o, 1'b1);

    // Pending interrupt blocks arming
    src_sel_i = 1'b0;
    clear_log();
    dr_scan(192'hABCD, 16, 1'b0);
    check("blk_nwr", wr_datas.size(), 0);
    check("blk_len", dr_len_o, 16'd32);

    pulse_clear();
    clear_log();
    dr_scan(192'hA5, 8, 1'b0);
    check("rearm_nwr", wr_datas.size(), 1);
    check("rearm_d0",  wr_datas[0], 32'h000000A5);
    check("rearm_len", dr_len_o, 16'd8);

    // Overflow with a 4-word RAM: drop mode, then wrap mode
    for (int unsigned i = 0; i < 6; i++) ov_data[i*32 +: 32] = 32'hC0DE0000 | i;
    pulse_clear();
    wrap_mode_i = 1'b0;
    clear_log();
    dr_scan(ov_data, 192, 1'b0);
    check("drop_nwr", wr_datas.size(), 4);
    for (int unsigned k = 0; k < 4; k++) begin
      check("drop_addr", wr_addrs[k], k[1:0]);
      check("drop_data", wr_datas[k], 32'hC0DE0000 | k);
    end
    check("drop_ovf", overflow_o, 1'b1);
    check("drop_len", dr_len_o, 16'd192);
    pulse_clear();
    check("clr_ovf", overflow_o, 1'b0);

    wrap_mode_i = 1'b1;
    clear_log();
    dr_scan(ov_data, 192, 1'b0);
    check("wrap_nwr", wr_datas.size(), 6);
    for (int unsigned k = 0; k < 6; k++) begin
      check("wrap_addr", wr_addrs[k], k[1:0]);
      check("wrap_data", wr_datas[k], 32'hC0DE0000 | k);
    end
    check("wrap_ovf", overflow_o, 1'b1);

    // TAP reset from ShDR: only the exit-edge flush is written
    pulse_clear();
    wrap_mode_i = 1'b0;
    clear_log();
    dr_enter();
    dr_bits(192'h3C, 8, 1'b0, 1'b0);
    repeat (5) tck_cycle(1'b1, 1'b1, 1'b0);
    wait_clk(4);
    check("tlr_nwr", wr_datas.size(), 1);
    check("tlr_d0",  wr_datas[0], 32'h0000013C);
    check("tlr_tap", tap_state_o, 4'hF);
    check("tlr_len", dr_len_o, 16'd9);
    check("tlr_ovf", overflow_o, 1'b0);
    tck_cycle(1'b0, 1'b0, 1'b0);

    // Reset in the middle of ShDR
    pulse_clear();
    clear_log();
    dr_enter();
    dr_bits(192'h2AA, 10, 1'b0, 1'b0);
    reset = 1'b1;
    wait_clk(3);
    check("mrst_tap",   tap_state_o, 4'hF);
    check("mrst_irval", ir_value_o, 8'h00);
    check("mrst_irlen", ir_len_o, 4'd0);
    check("mrst_len",   dr_len_o, 16'd0);
    check("mrst_int",   int_o, 1'b0);
    reset = 1'b0;
    wait_clk(4);
    check("mrst_nwr",   wr_datas.size(), 0);
    tck_cycle(1'b0, 1'b0, 1'b0);

    // Clear pulse lands on the exact cycle int is set; set must win
    clear_log();
    dr_enter();
    dr_bits(192'h0F, 8, 1'b0, 1'b1);
    TMS = 1'b1; TDI = 1'b0; TDO = 1'b0; TCK = 1'b0;
    wait_clk(4);
    TCK = 1'b1;
    wait_clk(2);
    clear_int_i = 1'b1;
    wait_clk(1);
    clear_int_i = 1'b0;
    wait_clk(3);
    check("sim_int",  int_o, 1'b1);
    check("sim_tap",  tap_state_o, 4'h5);
    check("sim_d0",   wr_datas[0], 32'h0000000F);
    pulse_clear();
    check("sim_clr",  int_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
